vga_fb_fetch_ctrl: RTL and testbench

- Frame-buffer fetch scheduler for the 1-bit VGA path, running in the vga_clk domain.
- Keeps the pixel FIFO topped up by issuing fixed-length burst reads of 16-bit words to the memory master port.
- Tracks frame position and restarts from the latched base address on every vertical sync.
- The pixel FIFO consumer (graph/timing logic) is outside this block.

---
 rtl/vga_fb_fetch_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_vga_fb_fetch_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_fetch_ctrl.sv
// vga_fb_fetch_ctrl: frame-buffer fetch scheduler for the 1-bit VGA path.
// Keeps the pixel FIFO topped up with fixed-length 16-bit burst reads and
// restarts from the latched base address on every vertical sync.
// Optional build macro: VGA_FETCH_UNDERRUN_EN adds sticky underrun detection;
// without it, underrun is tied low.
module vga_fb_fetch_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LEVEL_W     = 9,
    parameter int unsigned FIFO_DEPTH  = 256,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned FRAME_WORDS = 19200
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              vs_n,
    input  logic [LEVEL_W-1:0] fifo_usedw,
    output logic              fifo_clr,
    output logic              fifo_wr,
    output logic [15:0]       fifo_wdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic [7:0]        mem_burstcount,
    input  logic              mem_waitrequest,
    input  logic [15:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    output logic              underrun
);

    localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int unsigned OUT_W = LEVEL_W + 1;
    localparam int unsigned SUM_W = LEVEL_W + 2;

    localparam logic [CNT_W-1:0]  FRAME_LAST  = CNT_W'(FRAME_WORDS);
    localparam logic [SUM_W-1:0]  SPACE_LIMIT = SUM_W'(FIFO_DEPTH - BURST_LEN);
    localparam logic [ADDR_W-1:0] ADDR_STEP   = ADDR_W'(2 * BURST_LEN);
    localparam logic [OUT_W-1:0]  BURST_OUT   = OUT_W'(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        WAIT_SPACE,
        REQ,
        RECV,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              vs_d;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  word_cnt_next;
    logic [OUT_W-1:0]  outstanding;
    logic              pending;

    logic              frame_start;
    logic              beat;
    logic              discard;
    logic              space_ok;
    logic              restart;
    logic              accept;
    logic              set_pending;

    assign frame_start = vs_d & ~vs_n;
    assign beat        = (state == RECV) && mem_readdatavalid;
    // Data of a burst straddling a frame start belongs to the old frame.
    assign discard     = pending | frame_start;
    assign space_ok    = ({2'b00, fifo_usedw} + {1'b0, outstanding}) <= SPACE_LIMIT;

    // Word counter advances on kept beats and saturates at one frame.
    always_comb begin
        word_cnt_next = word_cnt;
        if (beat && !discard && (word_cnt != FRAME_LAST)) begin
            word_cnt_next = word_cnt + CNT_W'(1);
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        next_state  = state;
        restart     = 1'b0;
        accept      = 1'b0;
        set_pending = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && frame_start) restart = 1'b1;
            end
            FLUSH: begin
                if (frame_start) restart = 1'b1;
                else             next_state = WAIT_SPACE;
            end
            WAIT_SPACE: begin
                if (frame_start)                  restart = 1'b1;
                else if (!enable)                 next_state = IDLE;
                else if (word_cnt >= FRAME_LAST)  next_state = DONE;
                else if (space_ok)                next_state = REQ;
            end
            REQ: begin
                set_pending = frame_start;
                if (!mem_waitrequest) begin
                    accept     = 1'b1;
                    next_state = RECV;
                end
            end
            RECV: begin
                set_pending = frame_start;
                if (beat && (outstanding == OUT_W'(1))) begin
                    if (discard)                           restart = 1'b1;
                    else if (word_cnt_next == FRAME_LAST)  next_state = DONE;
                    else if (!enable)                      next_state = IDLE;
                    else                                   next_state = WAIT_SPACE;
                end
            end
            DONE: begin
                if (enable && frame_start) restart = 1'b1;
            end
            default: next_state = IDLE;
        endcase
        if (restart) next_state = FLUSH;
    end

    // State register.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Address, counters, pending frame start and the flush pulse.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vs_d        <= 1'b1;
            addr        <= '0;
            word_cnt    <= '0;
            outstanding <= '0;
            pending     <= 1'b0;
            fifo_clr    <= 1'b0;
        end else begin
            vs_d     <= vs_n;
            fifo_clr <= restart;
            if (restart) begin
                addr        <= base_addr;
                word_cnt    <= '0;
                outstanding <= '0;
                pending     <= 1'b0;
            end else begin
                if (accept) begin
                    addr        <= addr + ADDR_STEP;
                    outstanding <= outstanding + BURST_OUT;
                end else if (beat) begin
                    outstanding <= outstanding - OUT_W'(1);
                end
                word_cnt <= word_cnt_next;
                if (set_pending) pending <= 1'b1;
            end
        end
    end

    assign fifo_wr        = beat & ~discard;
    assign fifo_wdata     = fifo_wr ? mem_readdata : '0;
    assign mem_read       = (state == REQ);
    assign mem_address    = addr;
    assign mem_burstcount = 8'(BURST_LEN);

`ifdef VGA_FETCH_UNDERRUN_EN
    logic starve;
    logic starve_d;
    logic underrun_q;

    assign starve = (fifo_usedw == '0) &&
                    (state inside {WAIT_SPACE, REQ, RECV}) &&
                    (word_cnt < FRAME_LAST);

    // Sticky flag after two consecutive starved cycles; frame start clears it.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            starve_d   <= 1'b0;
            underrun_q <= 1'b0;
        end else if (restart) begin
            starve_d   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            starve_d <= starve;
            if (starve && starve_d) underrun_q <= 1'b1;
        end
    end

    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_fetch_ctrl.sv
// tb_vga_fb_fetch_ctrl: randomized bench for vga_fb_fetch_ctrl. A burst memory
// slave serves words whose value is a function of their byte address; the
// expected FIFO stream is simply the frame buffer read linearly from base.
module tb_vga_fb_fetch_ctrl;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned LEVEL_W     = 9;
    localparam int unsigned FIFO_DEPTH  = 256;
    localparam int unsigned BURST_LEN   = 16;
    localparam int unsigned FRAME_WORDS = 64;
    localparam int unsigned BURSTS      = FRAME_WORDS / BURST_LEN;
`ifdef VGA_FETCH_UNDERRUN_EN
    localparam logic UNDERRUN_EXP = 1'b1;
`else
    localparam logic UNDERRUN_EXP = 1'b0;
`endif

    logic               vga_clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [ADDR_W-1:0]  base_addr;
    logic               vs_n;
    logic [LEVEL_W-1:0] fifo_usedw;
    logic               fifo_clr;
    logic               fifo_wr;
    logic [15:0]        fifo_wdata;
    logic [ADDR_W-1:0]  mem_address;
    logic               mem_read;
    logic [7:0]         mem_burstcount;
    logic               mem_waitrequest;
    logic [15:0]        mem_readdata;
    logic               mem_readdatavalid;
    logic               underrun;

    always #5 vga_clk = ~vga_clk;

    vga_fb_fetch_ctrl #(
        .ADDR_W     (ADDR_W),
        .LEVEL_W    (LEVEL_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BURST_LEN  (BURST_LEN),
        .FRAME_WORDS(FRAME_WORDS)
    ) dut (
        .vga_clk          (vga_clk),
        .reset            (reset),
        .enable           (enable),
        .base_addr        (base_addr),
        .vs_n             (vs_n),
        .fifo_usedw       (fifo_usedw),
        .fifo_clr         (fifo_clr),
        .fifo_wr          (fifo_wr),
        .fifo_wdata       (fifo_wdata),
        .mem_address      (mem_address),
        .mem_read         (mem_read),
        .mem_burstcount   (mem_burstcount),
        .mem_waitrequest  (mem_waitrequest),
        .mem_readdata     (mem_readdata),
        .mem_readdatavalid(mem_readdatavalid),
        .underrun         (underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] acc_q[$];
    logic [7:0]  bc_q[$];
    logic [31:0] beat_q[$];
    logic [15:0] wr_q[$];
    int          clr_cnt;
    int          read_cnt;
    int          wait_mode;
    int          beat_budget;
    logic [15:0] salt;

    logic        obs_clr;
    logic        obs_read;
    logic        obs_under;
    logic [31:0] obs_addr;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[16:1] ^ salt;
    endfunction

    // One bus cycle: sample just before the rising edge, then drive the slave.
    task automatic cycle();
        #2;
        obs_clr   = fifo_clr;
        obs_read  = mem_read;
        obs_under = underrun;
        obs_addr  = mem_address;
        if (fifo_clr) clr_cnt++;
        if (fifo_wr) wr_q.push_back(fifo_wdata);
        if (mem_read) read_cnt++;
        if (mem_read && !mem_waitrequest) begin
            acc_q.push_back(mem_address);
            bc_q.push_back(mem_burstcount);
            for (int i = 0; i < int'(BURST_LEN); i++)
                beat_q.push_back(mem_address + 32'(2 * i));
        end
        @(negedge vga_clk);
        case (wait_mode)
            0:       mem_waitrequest = 1'($urandom_range(0, 1));
            1:       mem_waitrequest = 1'b0;
            default: mem_waitrequest = 1'b1;
        endcase
        mem_readdatavalid = 1'b0;
        mem_readdata      = 16'($urandom);
        if (beat_q.size() > 0 && beat_budget > 0 && $urandom_range(0, 3) != 0) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = mem_word(beat_q.pop_front());
            beat_budget--;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; vs_n = 1'b1; base_addr = '0; fifo_usedw = '0;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
        acc_q.delete(); bc_q.delete(); beat_q.delete(); wr_q.delete();
        clr_cnt = 0; read_cnt = 0; wait_mode = 0; beat_budget = 1000000;
        repeat (2) @(negedge vga_clk);
        reset = 1'b0;
    endtask

    task automatic frame_pulse();
        vs_n = 1'b0;
        cycle();
        cycle();
        vs_n = 1'b1;
    endtask

    task automatic run_until_acc(input int n, input int budget, output bit ok);
        int c = 0;
        while (acc_q.size() < n && c < budget) begin cycle(); c++; end
        ok = (acc_q.size() >= n);
    endtask

    task automatic run_until_idle(input int n, input int budget, output bit ok);
        int c = 0;
        while ((acc_q.size() < n || beat_q.size() != 0) && c < budget) begin cycle(); c++; end
        ok = (acc_q.size() >= n && beat_q.size() == 0);
        repeat (2) cycle();
    endtask

    task automatic run_until_clr(input int n, input int budget, output bit ok);
        int c = 0;
        while (clr_cnt < n && c < budget) begin cycle(); c++; end
        ok = (clr_cnt >= n);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; vs_n = 1'b1; base_addr = 32'h1234; fifo_usedw = '0;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b1; mem_readdata = 16'hBEEF;
        @(negedge vga_clk);
        #2;
        n_cmp++; if (fifo_clr !== 1'b0)     begin n_bad++; $display("FAIL rst_clr: got %b want 0", fifo_clr); end
        n_cmp++; if (fifo_wr !== 1'b0)      begin n_bad++; $display("FAIL rst_wr: got %b want 0", fifo_wr); end
        n_cmp++; if (fifo_wdata !== 16'h0)  begin n_bad++; $display("FAIL rst_wdata: got %h want 0", fifo_wdata); end
        n_cmp++; if (mem_read !== 1'b0)     begin n_bad++; $display("FAIL rst_read: got %b want 0", mem_read); end
        n_cmp++; if (mem_address !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", mem_address); end
        n_cmp++; if (underrun !== 1'b0)     begin n_bad++; $display("FAIL rst_underrun: got %b want 0", underrun); end
        n_cmp++; if (mem_burstcount !== 8'd16) begin n_bad++; $display("FAIL rst_bc: got %0d want 16", mem_burstcount); end
        @(negedge vga_clk);
        reset = 1'b0; mem_readdatavalid = 1'b0;
        acc_q.delete(); bc_q.delete(); beat_q.delete(); wr_q.delete();
        clr_cnt = 0; read_cnt = 0; wait_mode = 1; beat_budget = 1000000;
        repeat (6) cycle();
        n_cmp++; if (read_cnt != 0) begin n_bad++; $display("FAIL idle_no_read: got %0d reads want 0", read_cnt); end
        n_cmp++; if (clr_cnt != 0)  begin n_bad++; $display("FAIL idle_no_clr: got %0d clears want 0", clr_cnt); end
    endtask

    task automatic test_first_frame();
        bit ok;
        logic [15:0] got;
        do_reset();
        salt = 16'($urandom);
        base_addr = 32'h1000; enable = 1'b1; fifo_usedw = '0; wait_mode = 0;
        vs_n = 1'b0;
        cycle();
        n_cmp++; if (obs_clr !== 1'b0) begin n_bad++; $display("FAIL clr_early: got %b want 0", obs_clr); end
        cycle();
        n_cmp++; if (obs_clr !== 1'b1) begin n_bad++; $display("FAIL clr_pulse: got %b want 1", obs_clr); end
        vs_n = 1'b1;
        cycle();
        n_cmp++; if (obs_clr !== 1'b0) begin n_bad++; $display("FAIL clr_width: got %b want 0", obs_clr); end
        run_until_acc(2, 400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL first_timeout: got %0d bursts want 2", acc_q.size()); end
        n_cmp++; if (wr_q.size() != 16) begin n_bad++; $display("FAIL first_beats: got %0d writes want 16", wr_q.size()); end
        for (int k = 0; k < 2; k++) begin
            if (k < acc_q.size()) begin
                n_cmp++;
                if (acc_q[k] !== 32'h1000 + 32'(32 * k)) begin
                    n_bad++; $display("FAIL first_addr%0d: got %h want %h", k, acc_q[k], 32'h1000 + 32'(32 * k));
                end
                n_cmp++;
                if (bc_q[k] !== 8'd16) begin n_bad++; $display("FAIL first_bc%0d: got %0d want 16", k, bc_q[k]); end
            end
        end
        for (int i = 0; i < 16; i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
            n_cmp++;
            if (got !== mem_word(32'h1000 + 32'(2 * i))) begin
                n_bad++; $display("FAIL first_data%0d: got %h want %h", i, got, mem_word(32'h1000 + 32'(2 * i)));
            end
        end
    endtask

    task automatic test_threshold_stall();
        do_reset();
        salt = 16'($urandom);
        base_addr = 32'h3000; enable = 1'b1; fifo_usedw = 9'd241; wait_mode = 2;
        frame_pulse();
        repeat (20) cycle();
        n_cmp++; if (read_cnt != 0) begin n_bad++; $display("FAIL space_241: got %0d read cycles want 0", read_cnt); end
        fifo_usedw = 9'd240;
        cycle();
        n_cmp++; if (obs_read !== 1'b0) begin n_bad++; $display("FAIL space_drop_cycle: got %b want 0", obs_read); end
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++;
            if (obs_read !== 1'b1 || obs_addr !== 32'h3000) begin
                n_bad++; $display("FAIL stall%0d: got read=%b addr=%h want read=1 addr=00003000", i, obs_read, obs_addr);
            end
        end
        n_cmp++; if (acc_q.size() != 0) begin n_bad++; $display("FAIL stall_acc: got %0d accepts want 0", acc_q.size()); end
        wait_mode = 1; mem_waitrequest = 1'b0;
        cycle();
        cycle();
        n_cmp++; if (obs_read !== 1'b0) begin n_bad++; $display("FAIL after_acc_read: got %b want 0", obs_read); end
        n_cmp++; if (obs_addr !== 32'h3020) begin n_bad++; $display("FAIL after_acc_addr: got %h want 00003020", obs_addr); end
        n_cmp++;
        if (acc_q.size() != 1 || acc_q[0] !== 32'h3000) begin
            n_bad++; $display("FAIL stall_accept: got %0d accepts want 1 at 00003000", acc_q.size());
        end
    endtask

    task automatic test_frame_done();
        bit ok;
        int rd;
        logic [15:0] got;
        do_reset();
        salt = 16'($urandom);
        base_addr = 32'h1000; enable = 1'b1; fifo_usedw = 9'd100; wait_mode = 0;
        frame_pulse();
        run_until_idle(BURSTS, 2000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL done_timeout: got %0d bursts want %0d", acc_q.size(), BURSTS); end
        n_cmp++; if (acc_q.size() != BURSTS) begin n_bad++; $display("FAIL done_bursts: got %0d want %0d", acc_q.size(), BURSTS); end
        for (int k = 0; k < int'(BURSTS) && k < acc_q.size(); k++) begin
            n_cmp++;
            if (acc_q[k] !== 32'h1000 + 32'(32 * k)) begin
                n_bad++; $display("FAIL done_addr%0d: got %h want %h", k, acc_q[k], 32'h1000 + 32'(32 * k));
            end
        end
        n_cmp++; if (wr_q.size() != FRAME_WORDS) begin n_bad++; $display("FAIL done_words: got %0d want %0d", wr_q.size(), FRAME_WORDS); end
        for (int i = 0; i < int'(FRAME_WORDS); i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
            n_cmp++;
            if (got !== mem_word(32'h1000 + 32'(2 * i))) begin
                n_bad++; $display("FAIL done_data%0d: got %h want %h", i, got, mem_word(32'h1000 + 32'(2 * i)));
            end
        end
        rd = read_cnt;
        repeat (40) cycle();
        n_cmp++; if (read_cnt != rd) begin n_bad++; $display("FAIL done_quiet: got %0d read cycles want 0", read_cnt - rd); end
        frame_pulse();
        run_until_acc(BURSTS + 1, 300, ok);
        n_cmp++;
        if (!ok || acc_q[BURSTS] !== 32'h1000) begin
            n_bad++; $display("FAIL done_restart: got %0d bursts want restart at 00001000", acc_q.size());
        end
        n_cmp++; if (clr_cnt != 2) begin n_bad++; $display("FAIL done_clr: got %0d want 2", clr_cnt); end
    endtask

    task automatic test_midframe_restart();
        bit ok;
        int c;
        int wr_at_clr;
        do_reset();
        salt = 16'($urandom);
        base_addr = 32'h1000; enable = 1'b1; fifo_usedw = 9'd100; wait_mode = 1; beat_budget = 7;
        frame_pulse();
        run_until_acc(1, 200, ok);
        c = 0;
        while (wr_q.size() < 7 && c < 200) begin cycle(); c++; end
        repeat (3) cycle();
        n_cmp++; if (wr_q.size() != 7) begin n_bad++; $display("FAIL mid_pre_beats: got %0d want 7", wr_q.size()); end
        base_addr = 32'h8000;
        vs_n = 1'b0;
        cycle();
        cycle();
        vs_n = 1'b1;
        beat_budget = 1000000;
        run_until_clr(2, 300, ok);
        wr_at_clr = wr_q.size();
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_clr_timeout: got %0d clears want 2", clr_cnt); end
        n_cmp++; if (wr_at_clr != 7) begin n_bad++; $display("FAIL mid_discard: got %0d writes want 7", wr_at_clr); end
        for (int i = 0; i < 7 && i < wr_q.size(); i++) begin
            n_cmp++;
            if (wr_q[i] !== mem_word(32'h1000 + 32'(2 * i))) begin
                n_bad++; $display("FAIL mid_data%0d: got %h want %h", i, wr_q[i], mem_word(32'h1000 + 32'(2 * i)));
            end
        end
        run_until_idle(2, 300, ok);
        n_cmp++;
        if (!ok || acc_q[1] !== 32'h8000) begin
            n_bad++; $display("FAIL mid_new_base: got %0d bursts want second at 00008000", acc_q.size());
        end
        n_cmp++;
        if (wr_q.size() < 8 || wr_q[7] !== mem_word(32'h8000)) begin
            n_bad++; $display("FAIL mid_new_data: got %0d writes want word at 00008000 next", wr_q.size());
        end
    endtask

    task automatic test_underrun();
        bit ok;
        do_reset();
        salt = 16'($urandom);
        base_addr = 32'h2000; enable = 1'b1; fifo_usedw = 9'd100; wait_mode = 1;
        frame_pulse();
        run_until_acc(1, 200, ok);
        cycle();
        n_cmp++; if (obs_under !== 1'b0) begin n_bad++; $display("FAIL under_pre: got %b want 0", obs_under); end
        fifo_usedw = '0;
        repeat (3) cycle();
        fifo_usedw = 9'd100;
        repeat (2) cycle();
        n_cmp++; if (obs_under !== UNDERRUN_EXP) begin n_bad++; $display("FAIL under_set: got %b want %b", obs_under, UNDERRUN_EXP); end
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_cmp++;
            if (obs_under !== UNDERRUN_EXP) begin n_bad++; $display("FAIL under_hold%0d: got %b want %b", i, obs_under, UNDERRUN_EXP); end
        end
        frame_pulse();
        run_until_clr(2, 300, ok);
        n_cmp++;
        if (!ok || obs_under !== 1'b0) begin
            n_bad++; $display("FAIL under_clear: got %b clears=%0d want 0 after frame start", obs_under, clr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] base;
        logic [15:0] got;
        do_reset();
        enable = 1'b1;
        for (int it = 0; it < 3; it++) begin
            base = (it == 0) ? 32'hFFFF_FFE0 : ($urandom & 32'hFFFF_FFFE);
            salt = 16'($urandom);
            acc_q.delete(); bc_q.delete(); wr_q.delete(); clr_cnt = 0;
            base_addr = base; fifo_usedw = 9'($urandom_range(0, 240)); wait_mode = 0;
            frame_pulse();
            run_until_idle(BURSTS, 2000, ok);
            n_cmp++; if (!ok || clr_cnt != 1) begin n_bad++; $display("FAIL b2b%0d_frame: got %0d bursts %0d clears want %0d/1", it, acc_q.size(), clr_cnt, BURSTS); end
            for (int k = 0; k < int'(BURSTS) && k < acc_q.size(); k++) begin
                n_cmp++;
                if (acc_q[k] !== base + 32'(32 * k)) begin
                    n_bad++; $display("FAIL b2b%0d_addr%0d: got %h want %h", it, k, acc_q[k], base + 32'(32 * k));
                end
            end
            for (int i = 0; i < int'(FRAME_WORDS); i++) begin
                got = (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
                n_cmp++;
                if (got !== mem_word(base + 32'(2 * i))) begin
                    n_bad++; $display("FAIL b2b%0d_data%0d: got %h want %h", it, i, got, mem_word(base + 32'(2 * i)));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_threshold_stall();
        test_frame_done();
        test_midframe_restart();
        test_underrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
